// File: rtl/bingo_pkg.sv
// bingo_pkg: shared constants, FSM states and helpers for the Bingo card (BINGO_DIAG_EN selects diagonal lines)
package bingo_pkg;
    localparam int CELLS = 25;
    localparam int CELL_W = 5;
    localparam int MAP_W = CELLS * CELL_W;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] NULL_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SWAP} state_t;

    function automatic int cell_idx(int x, int y);
        return x + 5 * y;
    endfunction

    function automatic logic [MAP_W-1:0] identity_map();
        logic [MAP_W-1:0] m;
        for (int k = 0; k < CELLS; k++) m[CELL_W*k +: CELL_W] = CELL_W'(k + 1);
        return m;
    endfunction

    function automatic logic [15:0] lfsr_step(logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/bingo_board_if.sv
// bingo_board_if: request and status bundle between the card controller and bingo_board
interface bingo_board_if;
    import bingo_pkg::*;
    logic             shuffle_start;
    logic [15:0]      seed;
    logic             mark_valid;
    logic [4:0]       mark_num;
    logic [MAP_W-1:0] map;
    logic             busy;
    logic             shuffle_done;
    logic             mark_hit;
    logic             mark_miss;
    logic [3:0]       lines;
    logic             bingo;
    modport master (
        output shuffle_start, seed, mark_valid, mark_num,
        input  map, busy, shuffle_done, mark_hit, mark_miss, lines, bingo
    );
    modport slave (
        input  shuffle_start, seed, mark_valid, mark_num,
        output map, busy, shuffle_done, mark_hit, mark_miss, lines, bingo
    );
endinterface

// File: rtl/bingo_line_counter.sv
// bingo_line_counter: registered count of fully marked rows/columns (and diagonals when BINGO_DIAG_EN) plus win flag
module bingo_line_counter
    import bingo_pkg::*;
#(
    parameter int WIN_LINES = 5
) (
    input  logic             clk_25MHz,
    input  logic             all_rst,
    input  logic [MAP_W-1:0] i_map,
    output logic [3:0]       o_lines,
    output logic             o_bingo
);
    logic [24:0] w_zero;
    logic [11:0] w_full;
    logic [3:0]  w_cnt;

    // flag every complete line and add them up
    always_comb begin
        w_full = '0;
        w_cnt = '0;
        for (int k = 0; k < CELLS; k++) w_zero[k] = i_map[CELL_W*k +: CELL_W] == '0;
        for (int n = 0; n < 5; n++) begin
            w_full[n] = 1'b1;
            w_full[5+n] = 1'b1;
            for (int m = 0; m < 5; m++) begin
                w_full[n] &= w_zero[cell_idx(m, n)];
                w_full[5+n] &= w_zero[cell_idx(n, m)];
            end
        end
`ifdef BINGO_DIAG_EN
        w_full[10] = 1'b1;
        w_full[11] = 1'b1;
        for (int m = 0; m < 5; m++) begin
            w_full[10] &= w_zero[cell_idx(m, m)];
            w_full[11] &= w_zero[cell_idx(4 - m, m)];
        end
`endif
        for (int k = 0; k < 12; k++) w_cnt += 4'(w_full[k]);
    end

    // register the count and the win flag together
    always_ff @(posedge clk_25MHz or posedge all_rst) begin
        if (all_rst) begin
            o_lines <= '0;
            o_bingo <= 1'b0;
        end else begin
            o_lines <= w_cnt;
            o_bingo <= 32'(w_cnt) >= WIN_LINES;
        end
    end
endmodule

// File: rtl/bingo_board.sv
// bingo_board: 5x5 card state with LFSR Fisher-Yates shuffle, number marking and line detection (BINGO_DIAG_EN adds diagonals)
module bingo_board
    import bingo_pkg::*;
#(
    parameter int          WIN_LINES = 5,
    parameter logic [15:0] NULL_SEED = NULL_SEED_DEF
) (
    input  logic          clk_25MHz,
    input  logic          all_rst,
    bingo_board_if.slave  bus
);
    state_t           r_state, w_state;
    logic [15:0]      r_lfsr, w_lfsr;
    logic [4:0]       r_i, w_i;
    logic [MAP_W-1:0] r_map, w_map;
    logic             r_done, w_done;
    logic             r_hit, w_hit;
    logic             r_miss, w_miss;
    logic [24:0]      w_match;
    logic [4:0]       w_ip1, w_j, w_ci, w_cj;

    // parallel compare of the called number against all cells; 0 never matches
    always_comb begin
        for (int k = 0; k < CELLS; k++)
            w_match[k] = bus.mark_num != '0 && r_map[CELL_W*k +: CELL_W] == bus.mark_num;
    end

    // swap partner j in 0..i scaled from the low LFSR byte
    always_comb begin
        w_ip1 = r_i + 5'd1;
        w_j = 5'((13'(r_lfsr[7:0]) * 13'(w_ip1)) >> 8);
        w_ci = r_map[CELL_W*r_i +: CELL_W];
        w_cj = r_map[CELL_W*w_j +: CELL_W];
    end

    // next state and datapath; the seed is captured when the shuffle is accepted
    always_comb begin
        w_state = r_state;
        w_lfsr = r_lfsr;
        w_i = r_i;
        w_map = r_map;
        w_done = 1'b0;
        w_hit = 1'b0;
        w_miss = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.shuffle_start) begin
                    w_state = ST_INIT;
                    w_lfsr = bus.seed == '0 ? NULL_SEED : bus.seed;
                end else if (bus.mark_valid) begin
                    w_hit = |w_match;
                    w_miss = ~|w_match;
                    for (int k = 0; k < CELLS; k++)
                        if (w_match[k]) w_map[CELL_W*k +: CELL_W] = '0;
                end
            end
            ST_INIT: begin
                w_map = identity_map();
                w_i = 5'd24;
                w_state = ST_SWAP;
            end
            ST_SWAP: begin
                w_map[CELL_W*r_i +: CELL_W] = w_cj;
                w_map[CELL_W*w_j +: CELL_W] = w_ci;
                w_lfsr = lfsr_step(r_lfsr);
                w_i = r_i - 5'd1;
                if (r_i == 5'd1) begin
                    w_state = ST_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // state and card registers; reset discards any partial shuffle
    always_ff @(posedge clk_25MHz or posedge all_rst) begin
        if (all_rst) begin
            r_state <= ST_IDLE;
            r_lfsr <= NULL_SEED;
            r_i <= '0;
            r_map <= identity_map();
            r_done <= 1'b0;
            r_hit <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            r_state <= w_state;
            r_lfsr <= w_lfsr;
            r_i <= w_i;
            r_map <= w_map;
            r_done <= w_done;
            r_hit <= w_hit;
            r_miss <= w_miss;
        end
    end

    bingo_line_counter #(.WIN_LINES(WIN_LINES)) u_lines (
        .clk_25MHz (clk_25MHz),
        .all_rst   (all_rst),
        .i_map     (r_map),
        .o_lines   (bus.lines),
        .o_bingo   (bus.bingo)
    );

    assign bus.map = r_map;
    assign bus.busy = r_state != ST_IDLE;
    assign bus.shuffle_done = r_done;
    assign bus.mark_hit = r_hit;
    assign bus.mark_miss = r_miss;
endmodule

// File: tb/tb_bingo_board.sv
// tb_bingo_board: scoreboard bench for bingo_board marks, line counting, shuffles and reset
module tb_bingo_board;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    bingo_board_if bus();
    bingo_board dut (.clk_25MHz(clk), .all_rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int mdl[25];
    bit mq[$];
    logic [124:0] sq[$];
    bit e_hit;

    task automatic check(string tag, logic [124:0] got, logic [124:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [124:0] pack_mdl();
        logic [124:0] m;
        for (int k = 0; k < 25; k++) m[5*k +: 5] = 5'(mdl[k]);
        return m;
    endfunction

    function automatic int model_lines();
        int n = 0;
        bit r, c, d1, d2;
        d1 = 1;
        d2 = 1;
        for (int a = 0; a < 5; a++) begin
            r = 1;
            c = 1;
            for (int b = 0; b < 5; b++) begin
                r &= mdl[a*5+b] == 0;
                c &= mdl[b*5+a] == 0;
            end
            n += int'(r) + int'(c);
            d1 &= mdl[a*5+a] == 0;
            d2 &= mdl[a*5+4-a] == 0;
        end
`ifdef BINGO_DIAG_EN
        n += int'(d1) + int'(d2);
`endif
        return n;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 25; k++) mdl[k] = k + 1;
    endtask

    task automatic model_shuffle(logic [15:0] s);
        logic [15:0] l;
        int j, t;
        l = s == 16'h0 ? 16'hACE1 : s;
        reset_model();
        for (int i = 24; i >= 1; i--) begin
            j = (int'(l[7:0]) * (i + 1)) >> 8;
            t = mdl[i];
            mdl[i] = mdl[j];
            mdl[j] = t;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    task automatic do_mark(int n);
        bit h = 0;
        for (int k = 0; k < 25; k++)
            if (n != 0 && mdl[k] == n) begin
                h = 1;
                mdl[k] = 0;
            end
        mq.push_back(h);
        @(negedge clk);
        bus.mark_valid = 1'b1;
        bus.mark_num = 5'(n);
        @(negedge clk);
        bus.mark_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    task automatic do_shuffle(logic [15:0] s, bit with_mark);
        int nb = 0;
        int dk = 0;
        model_shuffle(s);
        sq.push_back(pack_mdl());
        @(negedge clk);
        bus.shuffle_start = 1'b1;
        bus.seed = s;
        bus.mark_valid = with_mark;
        bus.mark_num = 5'd5;
        @(negedge clk);
        bus.shuffle_start = 1'b0;
        bus.mark_valid = 1'b0;
        bus.seed = 16'h0;
        for (int k = 1; k <= 30; k++) begin
            if (bus.busy) nb++;
            if (bus.shuffle_done && dk == 0) dk = k;
            @(negedge clk);
        end
        check("busy_cycles", nb, 25);
        check("done_cycle", dk, 26);
        check("busy_after_shuffle", bus.busy, 0);
        check("lines_after_shuffle", bus.lines, 0);
    endtask

    // scoreboard: pop expected mark outcomes and shuffle maps as the DUT reports them
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mark_hit || bus.mark_miss) begin
                if (mq.size() == 0) check("mark_unexpected", {bus.mark_hit, bus.mark_miss}, 2'b00);
                else begin
                    e_hit = mq.pop_front();
                    check("mark_hit", bus.mark_hit, e_hit);
                    check("mark_miss", bus.mark_miss, !e_hit);
                end
            end
            if (bus.shuffle_done) begin
                if (sq.size() == 0) check("done_unexpected", bus.shuffle_done, 0);
                else check("shuffle_map", bus.map, sq.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        bus.shuffle_start = 1'b0;
        bus.seed = 16'h0;
        bus.mark_valid = 1'b0;
        bus.mark_num = 5'd0;
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_map", bus.map, pack_mdl());
        check("reset_cell0", bus.map[4:0], 5'd1);
        check("reset_cell24", bus.map[124:120], 5'd25);
        check("reset_lines", bus.lines, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_bingo", bus.bingo, 0);
        check("reset_done", bus.shuffle_done, 0);

        for (int n = 1; n <= 5; n++) do_mark(n);
        @(negedge clk);
        check("row_lines", bus.lines, model_lines());
        check("row_bingo", bus.bingo, 0);
        check("row_map", bus.map, pack_mdl());

        pulse_reset();
        foreach (mdl[k]) if (k % 6 == 0) do_mark(k + 1);
        @(negedge clk);
        check("diag_lines", bus.lines, model_lines());

        pulse_reset();
        do_mark(26);
        do_mark(0);
        do_mark(3);
        do_mark(3);
        @(negedge clk);
        check("miss_map", bus.map, pack_mdl());
        check("miss_lines", bus.lines, 0);

        for (int n = 1; n <= 25; n++) do_mark(n);
        @(negedge clk);
        check("full_lines", bus.lines, model_lines());
        check("full_bingo", bus.bingo, 1);

        do_shuffle(16'h0, 1'b1);
        do_shuffle(16'h0, 1'b1);
        do_shuffle(16'h1234, 1'b0);
        do_mark(13);
        @(negedge clk);
        check("shuffled_mark_map", bus.map, pack_mdl());

        @(negedge clk);
        bus.shuffle_start = 1'b1;
        bus.seed = 16'h5A5A;
        @(negedge clk);
        bus.shuffle_start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_shuffle_busy", bus.busy, 1);
        rst = 1'b1;
        reset_model();
        #1;
        check("abort_map", bus.map, pack_mdl());
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        do_mark(5);
        @(negedge clk);
        check("abort_mark_map", bus.map, pack_mdl());

        check("mark_queue_drained", mq.size(), 0);
        check("shuffle_queue_drained", sq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
